// File: rtl/coproc0_intc_if.sv
// Bus between the COP0 interrupt controller and its environment: raw lines,
// per-line configuration, stall/ack handshake and the registered request.
interface coproc0_intc_if #(
    parameter int NIRQ = 8,
    parameter int IDXW = 3
);
    logic [NIRQ-1:0] i_irq;
    logic [NIRQ-1:0] i_edge_mode;
    logic [NIRQ-1:0] i_mask;
    logic            i_ie;
    logic            i_core_stall;
    logic            i_ack;
    logic            i_clr;
    logic [IDXW-1:0] i_clr_idx;
    logic [NIRQ-1:0] o_pending;
    logic            o_intr;
    logic [IDXW-1:0] o_intr_idx;

    modport master (
        output i_irq, i_edge_mode, i_mask, i_ie, i_core_stall, i_ack, i_clr, i_clr_idx,
        input  o_pending, o_intr, o_intr_idx
    );

    modport slave (
        input  i_irq, i_edge_mode, i_mask, i_ie, i_core_stall, i_ack, i_clr, i_clr_idx,
        output o_pending, o_intr, o_intr_idx
    );
endinterface

// File: rtl/coproc0_intc.sv
// Multi-line interrupt capture and fixed-priority request unit for COP0.
// Lines are synchronised, edge lines latch into edge_pend, level lines pass
// straight through; one registered request (line index) is held until the
// exception unit acks it or the request is no longer eligible.
//
//   state | meaning
//   IDLE  | no request presented; may issue when not stalled
//   REQ   | o_intr=1, o_intr_idx frozen until ack or withdraw
module coproc0_intc #(
    parameter int NIRQ        = 8,
    parameter int IDXW        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          nrst,
    coproc0_intc_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] s_irq;
    logic [NIRQ-1:0] prev_q;
    logic [NIRQ-1:0] mode_q;
    logic [NIRQ-1:0] edge_pend_q, edge_pend_d;
    logic [NIRQ-1:0] pend_q;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] elig;
    logic [NIRQ-1:0] idx_sel;
    logic [NIRQ-1:0] sw_clr;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ-1:0] mode_clr;
    logic [NIRQ-1:0] edge_set;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] pick;
    logic            withdraw;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_irq = bus.i_irq;
        end else begin : g_sync
            logic [NIRQ-1:0] sync_q [SYNC_STAGES];

            // Shift the raw lines through the synchroniser chain, never stalled
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= bus.i_irq;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end

            assign s_irq = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Decode the requested index and the software-clear index to one-hot;
    // clear indices beyond the last line match nothing and are ignored
    always_comb begin
        idx_sel = '0;
        sw_clr  = '0;
        for (int i = 0; i < NIRQ; i++) begin
            idx_sel[i] = (idx_q == IDXW'(i));
            sw_clr[i]  = bus.i_clr && (bus.i_clr_idx == IDXW'(i));
        end
    end

    // Edge capture with clears; a new edge in the same cycle as a clear wins
    always_comb begin
        edge_set    = s_irq & ~prev_q & bus.i_edge_mode;
        ack_clr     = (state_q == REQ && bus.i_ack) ? (idx_sel & bus.i_edge_mode) : '0;
        mode_clr    = (state_q == IDLE) ? (mode_q ^ bus.i_edge_mode) : '0;
        edge_pend_d = (edge_pend_q & ~(ack_clr | sw_clr | mode_clr)) | edge_set;
        pending     = (edge_pend_q & bus.i_edge_mode) | (s_irq & ~bus.i_edge_mode);
        elig        = bus.i_ie ? (pending & bus.i_mask) : '0;
        withdraw    = ~|(idx_sel & elig);
    end

    // Fixed priority: lowest eligible index wins
    always_comb begin
        pick = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (elig[i]) pick = IDXW'(i);
        end
    end

    // Request FSM next state; REQ->IDLE->REQ yields the one-cycle re-request gap
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (!bus.i_core_stall && (|elig)) begin
                    state_d = REQ;
                    idx_d   = pick;
                end
            end
            REQ: begin
                if (bus.i_ack || withdraw) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, index, edge capture and pending registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            prev_q      <= '0;
            mode_q      <= '0;
            edge_pend_q <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            prev_q      <= s_irq;
            mode_q      <= bus.i_edge_mode;
            edge_pend_q <= edge_pend_d;
            pend_q      <= pending;
        end
    end

    assign bus.o_pending  = pend_q;
    assign bus.o_intr     = (state_q == REQ);
    assign bus.o_intr_idx = idx_q;
endmodule

// File: tb/tb_coproc0_intc.sv
// Directed bench for coproc0_intc (NIRQ=8, IDXW=4 so that out-of-range clear
// indices can be driven, SYNC_STAGES=2). Inputs change 1 ns after a rising
// edge; outputs are checked in the same window.
module tb_coproc0_intc;
    logic clk;
    logic nrst;
    int   n_checks = 0;
    int   n_fail   = 0;

    coproc0_intc_if #(.NIRQ(8), .IDXW(4)) bus ();

    coproc0_intc #(.NIRQ(8), .IDXW(4), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        nrst                = 1'b0;
        bus.i_irq           = '0;
        bus.i_edge_mode     = 8'hFF;
        bus.i_mask          = 8'hFF;
        bus.i_ie            = 1'b1;
        bus.i_core_stall    = 1'b0;
        bus.i_ack           = 1'b0;
        bus.i_clr           = 1'b0;
        bus.i_clr_idx       = '0;
        #3;
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr actual=%0b required=0", bus.o_intr); end
        n_checks++; if (bus.o_intr_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx actual=%0d required=0", bus.o_intr_idx); end
        n_checks++; if (bus.o_pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending actual=%h required=00", bus.o_pending); end
        step(2);
        nrst = 1'b1;
        step(3);
    endtask

    task automatic test_edge_basic;
        bus.i_irq[3] = 1'b1;
        step(1);
        bus.i_irq[3] = 1'b0;
        step(2);
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL edge_latency_early actual=%0b required=0", bus.o_intr); end
        step(1);
        n_checks++; if (bus.o_intr !== 1'b1) begin n_fail++; $display("FAIL edge_intr actual=%0b required=1", bus.o_intr); end
        n_checks++; if (bus.o_intr_idx !== 4'd3) begin n_fail++; $display("FAIL edge_idx actual=%0d required=3", bus.o_intr_idx); end
        n_checks++; if (bus.o_pending !== 8'h08) begin n_fail++; $display("FAIL edge_pending actual=%h required=08", bus.o_pending); end
        step(2);
        bus.i_ack = 1'b1;
        step(1);
        bus.i_ack = 1'b0;
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL edge_ack_drop actual=%0b required=0", bus.o_intr); end
        step(1);
        n_checks++; if (bus.o_pending[3] !== 1'b0) begin n_fail++; $display("FAIL edge_ack_clears actual=%0b required=0", bus.o_pending[3]); end
        for (int c = 0; c < 8; c++) begin
            step(1);
            n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL edge_no_rereq cycle=%0d actual=%0b required=0", c, bus.o_intr); end
        end
    endtask

    task automatic test_priority;
        bus.i_irq[5] = 1'b1;
        bus.i_irq[2] = 1'b1;
        step(1);
        bus.i_irq[5] = 1'b0;
        bus.i_irq[2] = 1'b0;
        step(3);
        n_checks++; if (bus.o_intr !== 1'b1) begin n_fail++; $display("FAIL prio_intr actual=%0b required=1", bus.o_intr); end
        n_checks++; if (bus.o_intr_idx !== 4'd2) begin n_fail++; $display("FAIL prio_idx actual=%0d required=2", bus.o_intr_idx); end
        bus.i_irq[0] = 1'b1;
        step(1);
        bus.i_irq[0] = 1'b0;
        step(3);
        n_checks++; if (bus.o_intr_idx !== 4'd2) begin n_fail++; $display("FAIL prio_frozen actual=%0d required=2", bus.o_intr_idx); end
        n_checks++; if (bus.o_pending !== 8'h25) begin n_fail++; $display("FAIL prio_pending actual=%h required=25", bus.o_pending); end
        bus.i_ack = 1'b1;
        step(1);
        bus.i_ack = 1'b0;
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL prio_gap1 actual=%0b required=0", bus.o_intr); end
        step(1);
        n_checks++; if (bus.o_intr !== 1'b1 || bus.o_intr_idx !== 4'd0) begin n_fail++; $display("FAIL prio_second intr=%0b idx=%0d required 1/0", bus.o_intr, bus.o_intr_idx); end
        bus.i_ack = 1'b1;
        step(1);
        bus.i_ack = 1'b0;
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL prio_gap2 actual=%0b required=0", bus.o_intr); end
        step(1);
        n_checks++; if (bus.o_intr !== 1'b1 || bus.o_intr_idx !== 4'd5) begin n_fail++; $display("FAIL prio_third intr=%0b idx=%0d required 1/5", bus.o_intr, bus.o_intr_idx); end
        bus.i_ack = 1'b1;
        step(1);
        bus.i_ack = 1'b0;
        step(2);
        n_checks++; if (bus.o_intr !== 1'b0 || bus.o_pending !== 8'h00) begin n_fail++; $display("FAIL prio_drained intr=%0b pending=%h required 0/00", bus.o_intr, bus.o_pending); end
    endtask

    task automatic test_stall_capture;
        int stall_fail;
        stall_fail = 0;
        bus.i_core_stall = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) bus.i_irq[6] = 1'b1;
            if (c == 4) bus.i_irq[6] = 1'b0;
            if (bus.o_intr !== 1'b0) stall_fail++;
            step(1);
        end
        n_checks++; if (stall_fail != 0) begin n_fail++; $display("FAIL stall_no_req cycles_with_intr actual=%0d required=0", stall_fail); end
        n_checks++; if (bus.o_pending[6] !== 1'b1) begin n_fail++; $display("FAIL stall_captured actual=%0b required=1", bus.o_pending[6]); end
        bus.i_core_stall = 1'b0;
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL stall_release_same actual=%0b required=0", bus.o_intr); end
        step(1);
        n_checks++; if (bus.o_intr !== 1'b1 || bus.o_intr_idx !== 4'd6) begin n_fail++; $display("FAIL stall_req intr=%0b idx=%0d required 1/6", bus.o_intr, bus.o_intr_idx); end
        bus.i_core_stall = 1'b1;
        bus.i_ack = 1'b1;
        step(1);
        bus.i_ack = 1'b0;
        bus.i_core_stall = 1'b0;
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL stall_ack_honoured actual=%0b required=0", bus.o_intr); end
        step(3);
    endtask

    task automatic test_level_withdraw;
        bus.i_edge_mode[1] = 1'b0;
        bus.i_irq[1] = 1'b1;
        step(3);
        n_checks++; if (bus.o_intr !== 1'b1 || bus.o_intr_idx !== 4'd1) begin n_fail++; $display("FAIL level_req intr=%0b idx=%0d required 1/1", bus.o_intr, bus.o_intr_idx); end
        step(3);
        bus.i_irq[1] = 1'b0;
        step(2);
        n_checks++; if (bus.o_intr !== 1'b1) begin n_fail++; $display("FAIL level_hold actual=%0b required=1", bus.o_intr); end
        step(1);
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL level_withdraw actual=%0b required=0", bus.o_intr); end
        n_checks++; if (bus.o_pending[1] !== 1'b0) begin n_fail++; $display("FAIL level_pending actual=%0b required=0", bus.o_pending[1]); end
        bus.i_edge_mode[1] = 1'b1;
        step(3);
    endtask

    task automatic test_mask_ie;
        bus.i_mask = 8'hEF;
        bus.i_irq[4] = 1'b1;
        step(1);
        bus.i_irq[4] = 1'b0;
        step(4);
        n_checks++; if (bus.o_pending[4] !== 1'b1) begin n_fail++; $display("FAIL mask_pending actual=%0b required=1", bus.o_pending[4]); end
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL mask_blocks actual=%0b required=0", bus.o_intr); end
        bus.i_mask = 8'hFF;
        step(1);
        n_checks++; if (bus.o_intr !== 1'b1 || bus.o_intr_idx !== 4'd4) begin n_fail++; $display("FAIL mask_req intr=%0b idx=%0d required 1/4", bus.o_intr, bus.o_intr_idx); end
        bus.i_ie = 1'b0;
        step(1);
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL ie_withdraw actual=%0b required=0", bus.o_intr); end
        step(1);
        n_checks++; if (bus.o_pending[4] !== 1'b1) begin n_fail++; $display("FAIL ie_keeps_pend actual=%0b required=1", bus.o_pending[4]); end
        bus.i_ie = 1'b1;
        step(1);
        n_checks++; if (bus.o_intr !== 1'b1 || bus.o_intr_idx !== 4'd4) begin n_fail++; $display("FAIL ie_rereq intr=%0b idx=%0d required 1/4", bus.o_intr, bus.o_intr_idx); end
        bus.i_ack = 1'b1;
        step(1);
        bus.i_ack = 1'b0;
        step(3);
    endtask

    task automatic test_clear_and_reset;
        bus.i_mask = 8'h00;
        bus.i_irq[2] = 1'b1;
        step(1);
        bus.i_irq[2] = 1'b0;
        step(1);
        bus.i_clr = 1'b1;
        bus.i_clr_idx = 4'd2;
        step(1);
        bus.i_clr = 1'b0;
        step(1);
        n_checks++; if (bus.o_pending[2] !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins actual=%0b required=1", bus.o_pending[2]); end
        bus.i_clr = 1'b1;
        bus.i_clr_idx = 4'd9;
        bus.i_ack = 1'b1;
        step(1);
        bus.i_clr = 1'b0;
        bus.i_ack = 1'b0;
        step(1);
        n_checks++; if (bus.o_pending[2] !== 1'b1) begin n_fail++; $display("FAIL clr_out_of_range actual=%0b required=1", bus.o_pending[2]); end
        n_checks++; if (bus.o_intr !== 1'b0) begin n_fail++; $display("FAIL clr_masked_intr actual=%0b required=0", bus.o_intr); end
        bus.i_clr = 1'b1;
        bus.i_clr_idx = 4'd2;
        step(1);
        bus.i_clr = 1'b0;
        step(1);
        n_checks++; if (bus.o_pending[2] !== 1'b0) begin n_fail++; $display("FAIL clr_effective actual=%0b required=0", bus.o_pending[2]); end
        bus.i_mask = 8'hFF;
        bus.i_irq[7] = 1'b1;
        step(1);
        bus.i_irq[7] = 1'b0;
        step(3);
        n_checks++; if (bus.o_intr !== 1'b1 || bus.o_intr_idx !== 4'd7) begin n_fail++; $display("FAIL rst_pre_req intr=%0b idx=%0d required 1/7", bus.o_intr, bus.o_intr_idx); end
        #2;
        nrst = 1'b0;
        #1;
        n_checks++; if (bus.o_intr !== 1'b0 || bus.o_intr_idx !== 4'd0) begin n_fail++; $display("FAIL rst_async intr=%0b idx=%0d required 0/0", bus.o_intr, bus.o_intr_idx); end
        n_checks++; if (bus.o_pending !== 8'h00) begin n_fail++; $display("FAIL rst_async_pending actual=%h required=00", bus.o_pending); end
        step(1);
        nrst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1);
            n_checks++; if (bus.o_intr !== 1'b0 || bus.o_pending !== 8'h00) begin n_fail++; $display("FAIL rst_state_lost cycle=%0d intr=%0b pending=%h required 0/00", c, bus.o_intr, bus.o_pending); end
        end
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_priority();
        test_stall_capture();
        test_level_withdraw();
        test_mask_ie();
        test_clear_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
